// File: rtl/aes_encipher_if.sv
// Bundle between the AES encipher round engine and its surroundings: control,
// key-memory lookup, shared S-box port and the data block.
interface aes_encipher_if;
  // Handshake: with ready=1 the engine is idle; a one-cycle next=1 starts an
  // operation (keylen is captured on the same edge). ready drops on that edge
  // and stays low until new_block holds the ciphertext. next while busy is ignored.
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;
  logic [1:0]   dbg_state;

  modport master (
    output next, keylen, round_key, new_sboxw, block,
    input  round, sboxw, new_block, ready, dbg_state
  );

  modport slave (
    input  next, keylen, round_key, new_sboxw, block,
    output round, sboxw, new_block, ready, dbg_state
  );
endinterface

// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher round engine; SubBytes runs one word per
// cycle through an external S-box, round keys are fetched by round index.
module aes_encipher_block (
  input  logic          clk,
  input  logic          reset_n,
  aes_encipher_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, SBOX = 2'd2, MAIN = 2'd3} state_t;

  localparam logic [3:0] NR_128 = 4'ha;
  localparam logic [3:0] NR_256 = 4'he;

  state_t       state_q, state_d;
  logic [31:0]  w_q [4];
  logic [31:0]  w_d [4];
  logic [3:0]   w_we;
  logic [3:0]   round_q, round_d;
  logic [3:0]   nr_q, nr_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         ready_q, ready_d;
  logic [127:0] state_blk, init_blk, main_blk, final_blk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  // Row r of output word i comes from word (i+r) mod 4; row 0 is the top byte.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_word(s[127:96]), mix_word(s[95:64]),
            mix_word(s[63:32]),  mix_word(s[31:0])};
  endfunction

  assign state_blk = {w_q[0], w_q[1], w_q[2], w_q[3]};
  assign init_blk  = bus.block ^ bus.round_key;
  assign main_blk  = mix_columns(shift_rows(state_blk)) ^ bus.round_key;
  assign final_blk = shift_rows(state_blk) ^ bus.round_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      round_q     <= 4'd0;
      nr_q        <= NR_128;
      sword_ctr_q <= 2'd0;
      ready_q     <= 1'b1;
      for (int i = 0; i < 4; i++) w_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      nr_q        <= nr_d;
      sword_ctr_q <= sword_ctr_d;
      ready_q     <= ready_d;
      for (int i = 0; i < 4; i++) begin
        if (w_we[i]) w_q[i] <= w_d[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    nr_d        = nr_q;
    sword_ctr_d = sword_ctr_q;
    ready_d     = ready_q;
    w_we        = 4'b0000;
    for (int i = 0; i < 4; i++) w_d[i] = w_q[i];

    case (state_q)
      IDLE: begin
        if (bus.next) begin
          ready_d = 1'b0;
          round_d = 4'd0;
          nr_d    = bus.keylen ? NR_256 : NR_128;
          state_d = INIT;
        end
      end
      INIT: begin
        for (int i = 0; i < 4; i++) w_d[i] = init_blk[127 - 32*i -: 32];
        w_we        = 4'b1111;
        round_d     = 4'd1;
        sword_ctr_d = 2'd0;
        state_d     = SBOX;
      end
      SBOX: begin
        w_d[sword_ctr_q]  = bus.new_sboxw;
        w_we[sword_ctr_q] = 1'b1;
        sword_ctr_d       = sword_ctr_q + 2'd1;
        if (sword_ctr_q == 2'd3) state_d = MAIN;
      end
      MAIN: begin
        w_we        = 4'b1111;
        sword_ctr_d = 2'd0;
        if (round_q < nr_q) begin
          for (int i = 0; i < 4; i++) w_d[i] = main_blk[127 - 32*i -: 32];
          round_d = round_q + 4'd1;
          state_d = SBOX;
        end else begin
          // Final round skips MixColumns; round stays at Nr until the next start.
          for (int i = 0; i < 4; i++) w_d[i] = final_blk[127 - 32*i -: 32];
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.sboxw     = (state_q == SBOX) ? w_q[sword_ctr_q] : 32'd0;
    bus.new_block = state_blk;
    bus.round     = round_q;
    bus.ready     = ready_q;
    bus.dbg_state = state_q;
  end
endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: S-box and key memory models, FIPS-197 vectors,
// busy-start rejection, mid-operation reset and back-to-back operation.
module tb_aes_encipher_block;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  aes_encipher_if bus();

  aes_encipher_block dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] key_r;
  logic         key_len_r;

  typedef struct {
    logic         len;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [3:0]   nr;
    int           lat;
  } vec_t;
  vec_t vecs [3];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p, sq, s, x;
    p  = 8'h01;
    sq = a;
    for (int i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      p  = gmul(p, sq);
    end
    s = p;
    x = p;
    for (int i = 0; i < 4; i++) begin
      x = {x[6:0], x[7]};
      s = s ^ x;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_model(input logic [255:0] k, input logic len,
                                             input logic [3:0] r);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk, ri;
    nk = len ? 8 : 4;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = 32'd0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 64; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    ri = int'(r);
    if (ri > 14) ri = 14;
    return {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
  endfunction

  assign bus.new_sboxw = sub_word(bus.sboxw);
  assign bus.round_key = key_model(key_r, key_len_r, bus.round);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Starts one operation and follows it cycle by cycle until ready rises.
  // c counts negedges after the start edge E0, so ready seen at c means it rose at E0+c.
  task automatic run_op(input logic len, input logic [255:0] k, input logic [127:0] pt,
                        input logic [3:0] nr, input logic hold, input int poke_at,
                        output int lat);
    logic [127:0] x0;
    int           exp_r;
    key_r     = k;
    key_len_r = len;
    x0        = pt ^ key_model(k, len, 4'd0);
    lat       = -1;
    @(negedge clk);
    bus.block  = pt;
    bus.keylen = len;
    bus.next   = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 200; c++) begin
      @(negedge clk);
      if (c == poke_at) begin
        bus.next   = 1'b1;
        bus.keylen = ~len;
      end else if (!hold) begin
        bus.next = 1'b0;
      end
      if (bus.ready) begin
        lat = c;
        break;
      end
      exp_r = (c == 0) ? 0 : 1 + (c - 1) / 5;
      if (exp_r > int'(nr)) exp_r = int'(nr);
      check("round_seq", bus.round, exp_r);
      if (c == 0 || (c - 1) % 5 == 4) check("sboxw_not_sbox", bus.sboxw, 0);
      else if (c <= 4) check("sboxw_first_round", bus.sboxw, x0[127 - 32*(c-1) -: 32]);
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: actual ready low after 200 cycles required rise");
    end
  endtask

  int lat, gap;

  initial begin
    reset_n    = 1'b0;
    bus.next   = 1'b0;
    bus.keylen = 1'b0;
    bus.block  = 128'd0;
    key_r      = 256'd0;
    key_len_r  = 1'b0;

    vecs[0] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'ha, 51};
    vecs[1] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff,
                128'h8ea2b7ca516745bfeafc49904b496089, 4'he, 71};
    vecs[2] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h0,
                128'hc6a13b37878f5b826f4f8162a1c8d879, 4'ha, 51};

    repeat (2) @(negedge clk);
    check("reset_new_block", bus.new_block, 0);
    check("reset_ready", bus.ready, 1);
    check("reset_round", bus.round, 0);
    check("reset_sboxw", bus.sboxw, 0);
    check("reset_state", bus.dbg_state, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ready_hold", bus.ready, 1);

    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].len, vecs[i].key, vecs[i].pt, vecs[i].nr, 1'b0, -1, lat);
      check("latency", lat, vecs[i].lat);
      check("ciphertext", bus.new_block, vecs[i].ct);
      check("final_round", bus.round, vecs[i].nr);
      check("sboxw_done", bus.sboxw, 0);
      repeat (2) @(negedge clk);
      check("idle_ready", bus.ready, 1);
      check("idle_result_held", bus.new_block, vecs[i].ct);
    end

    // next pulsed mid-run with keylen flipped must not restart or change Nr.
    run_op(1'b0, vecs[0].key, vecs[0].pt, 4'ha, 1'b0, 20, lat);
    check("busy_latency", lat, 51);
    check("busy_ciphertext", bus.new_block, vecs[0].ct);
    check("busy_final_round", bus.round, 4'ha);

    // Asynchronous reset in the middle of an operation.
    key_r     = vecs[0].key;
    key_len_r = 1'b0;
    @(negedge clk);
    bus.block  = vecs[0].pt;
    bus.keylen = 1'b0;
    bus.next   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.next = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_before_reset", bus.ready, 0);
    reset_n = 1'b0;
    #1;
    check("midreset_new_block", bus.new_block, 0);
    check("midreset_ready", bus.ready, 1);
    check("midreset_round", bus.round, 0);
    check("midreset_sboxw", bus.sboxw, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(1'b0, vecs[0].key, vecs[0].pt, 4'ha, 1'b0, -1, lat);
    check("post_reset_latency", lat, 51);
    check("post_reset_ciphertext", bus.new_block, vecs[0].ct);

    // next held high: restart on the edge after ready rises, so 1 idle cycle + 51.
    run_op(1'b0, vecs[0].key, vecs[0].pt, 4'ha, 1'b1, -1, lat);
    check("b2b_first_latency", lat, 51);
    check("b2b_first_ciphertext", bus.new_block, vecs[0].ct);
    bus.block = 128'd0;
    gap = -1;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (j == 1) check("b2b_restart", bus.ready, 0);
      else if (bus.ready) begin
        gap = j;
        break;
      end
    end
    bus.next = 1'b0;
    check("b2b_gap", gap, 52);
    check("b2b_second_ciphertext", bus.new_block, vecs[2].ct);
    repeat (2) @(negedge clk);
    check("b2b_no_third_start", bus.ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
